// File: rtl/ac_ph_frame_arbiter_pkg.sv
// Shared types and helpers for the AC_PH frame arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ac_ph_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2
  } state_t;

  // Width of the core's phase/magnitude results.
  localparam int RES_W = 32;

  // Largest requester count the round-robin helper handles.
  localparam int MAX_REQ = 16;

  // First set bit of vec scanning upward from last+1, wrapping at n.
  // Returns last unchanged when vec has no bit set below n.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] vec,
                                         input logic [3:0] last,
                                         input int n);
    logic [3:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = 4'((int'(last) + i) % n);
      if (i <= n && !found && vec[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ac_ph_frame_arbiter_if.sv
// Requester, core and result signals of the AC_PH frame arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_rdy per requester; core side has none.
interface ac_ph_frame_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int X_WIDTH = 16,
  parameter int ID_W    = $clog2(NREQ)
);
  import ac_ph_arb_pkg::*;

  logic [NREQ-1:0]         req_vld;
  logic [NREQ*X_WIDTH-1:0] req_x1;
  logic [NREQ*X_WIDTH-1:0] req_x2;
  logic [NREQ-1:0]         req_rdy;
  logic                    core_i_vld;
  logic [X_WIDTH-1:0]      core_x1;
  logic [X_WIDTH-1:0]      core_x2;
  logic                    core_o_vld;
  logic                    core_finish;
  logic [RES_W-1:0]        core_ph;
  logic [RES_W-1:0]        core_ac;
  logic                    res_vld;
  logic [ID_W-1:0]         res_id;
  logic [RES_W-1:0]        res_ph;
  logic [RES_W-1:0]        res_ac;
  logic                    busy;
  logic                    timeout_err;

  // Arbiter view.
  modport slave (
    input  req_vld, req_x1, req_x2, core_o_vld, core_finish, core_ph, core_ac,
    output req_rdy, core_i_vld, core_x1, core_x2,
    output res_vld, res_id, res_ph, res_ac, busy, timeout_err
  );

  // Environment view (front-ends, core and result consumer).
  modport master (
    output req_vld, req_x1, req_x2, core_o_vld, core_finish, core_ph, core_ac,
    input  req_rdy, core_i_vld, core_x1, core_x2,
    input  res_vld, res_id, res_ph, res_ac, busy, timeout_err
  );

endinterface

// File: rtl/ac_ph_frame_arbiter_rr.sv
// Round-robin pick among requesters, starting after the last served one.
// Latency: pick is combinational; last_grant updates on the clock after upd.
// Backpressure: none; the caller decides when a pick is taken.
module rr_arbiter
  import ac_ph_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  input  logic [ID_W-1:0] upd_id,
  output logic [ID_W-1:0] pick,
  output logic            any
);

  logic [ID_W-1:0] last_grant;

  assign pick = ID_W'(rr_pick(MAX_REQ'(req), 4'(last_grant), NREQ));
  assign any  = |req;

  // Remember the requester whose frame just closed; reset favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(NREQ - 1);
    end else if (upd) begin
      last_grant <= upd_id;
    end
  end

endmodule

// File: rtl/ac_ph_frame_arbiter.sv
// Grants one AC_PH core to a requester per frame and returns its tagged result.
// Latency: sample to core 1 cycle; final result to res_vld 1 cycle.
// Backpressure: only the granted requester sees req_rdy, and only while streaming.
module ac_ph_frame_arbiter
  import ac_ph_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int X_WIDTH      = 16,
  parameter int FRAME_LENGTH = 5,
  parameter int TIMEOUT      = 1024,
  parameter int ID_W         = $clog2(NREQ)
) (
  input  logic           clk,
  input  logic           rst,
  ac_ph_frame_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_LENGTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] pick;
  logic            any_req;
  logic [NREQ-1:0] rdy_vec;
  logic            accept;
  logic            final_res;
  logic            tmo_hit;
  logic            frame_end;
  logic [CNT_W-1:0] sample_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_vld),
    .upd    (frame_end),
    .upd_id (grant),
    .pick   (pick),
    .any    (any_req)
  );

  assign bus.req_rdy = rdy_vec;
  assign bus.busy    = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, ready, accept and frame-close decode.
  always_comb begin
    state_nxt = state;
    rdy_vec   = '0;
    accept    = 1'b0;
    final_res = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = STREAM;
      end
      STREAM: begin
        rdy_vec[grant] = 1'b1;
        accept         = bus.req_vld[grant];
        if (accept && sample_cnt == CNT_W'(FRAME_LENGTH - 1)) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        // A final result arriving on the timeout cycle takes precedence.
        final_res = bus.core_o_vld && bus.core_finish;
        tmo_hit   = !final_res && (tmo_cnt == TMO_W'(TIMEOUT - 1));
        if (final_res || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    frame_end = final_res || tmo_hit;
  end

  // Grant capture, frame sample counter and result-wait timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      sample_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      if (state == IDLE && any_req) grant <= pick;
      if (accept) begin
        sample_cnt <= (sample_cnt == CNT_W'(FRAME_LENGTH - 1)) ? '0 : sample_cnt + 1'b1;
      end
      tmo_cnt <= (state == WAIT_RES) ? tmo_cnt + 1'b1 : '0;
    end
  end

  // Register accepted samples toward the core; data holds between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.core_i_vld <= 1'b0;
      bus.core_x1    <= '0;
      bus.core_x2    <= '0;
    end else begin
      bus.core_i_vld <= accept;
      if (accept) begin
        bus.core_x1 <= bus.req_x1[int'(grant)*X_WIDTH +: X_WIDTH];
        bus.core_x2 <= bus.req_x2[int'(grant)*X_WIDTH +: X_WIDTH];
      end
    end
  end

  // Capture the final result tagged with the owner; pulse errors on timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_vld     <= 1'b0;
      bus.res_id      <= '0;
      bus.res_ph      <= '0;
      bus.res_ac      <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.res_vld     <= final_res;
      bus.timeout_err <= tmo_hit;
      if (final_res) begin
        bus.res_id <= grant;
        bus.res_ph <= bus.core_ph;
        bus.res_ac <= bus.core_ac;
      end
    end
  end

endmodule

// File: tb/tb_ac_ph_frame_arbiter.sv
// Directed bench for the AC_PH frame arbiter with a hand-driven core model.
// Latency: checks 1-cycle sample forwarding and 1-cycle result reporting.
// Backpressure: requesters hold valid until their req_rdy is seen.
module tb_ac_ph_frame_arbiter;
  import ac_ph_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int XW   = 16;
  localparam int FL   = 5;
  localparam int TMO  = 16;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ac_ph_frame_arbiter_if #(.NREQ(NREQ), .X_WIDTH(XW), .ID_W(IDW)) bus ();

  ac_ph_frame_arbiter #(
    .NREQ(NREQ), .X_WIDTH(XW), .FRAME_LENGTH(FL), .TIMEOUT(TMO), .ID_W(IDW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Monitor: samples 2 time units after each falling edge.
  int n_ivld  = 0;
  int n_res   = 0;
  int n_tmo   = 0;
  int n_multi = 0;
  int gq[$];
  logic [NREQ-1:0] prev_rdy = '0;

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_rdy = '0;
    end else begin
      if (bus.core_i_vld)  n_ivld++;
      if (bus.res_vld)     n_res++;
      if (bus.timeout_err) n_tmo++;
      if (!$onehot0(bus.req_rdy)) n_multi++;
      if (bus.req_rdy != '0 && prev_rdy == '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_rdy[i]) gq.push_back(i);
      end
      prev_rdy = bus.req_rdy;
    end
  end

  // Present one sample, wait for ready, then check it reaches the core a cycle later.
  task automatic send(input int id, input logic [15:0] x1, input logic [15:0] x2, input string tag);
    int k;
    k = 0;
    bus.req_vld[id] = 1'b1;
    bus.req_x1[id*XW +: XW] = x1;
    bus.req_x2[id*XW +: XW] = x2;
    while (!bus.req_rdy[id] && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_rdy_seen"}, 32'(k < 200), 1);
    @(negedge clk);
    chk({tag, "_ivld"}, 32'(bus.core_i_vld), 1);
    chk({tag, "_x1"}, 32'(bus.core_x1), 32'(x1));
    chk({tag, "_x2"}, 32'(bus.core_x2), 32'(x2));
  endtask

  // Core model: wait for the result phase, give a final result, check the report.
  task automatic respond(input logic [31:0] ph, input logic [31:0] ac, input int exp_id, input string tag);
    int k;
    k = 0;
    while (!(bus.busy && bus.req_rdy == '0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_waitres"}, 32'(k < 200), 1);
    @(negedge clk);
    bus.core_o_vld  = 1'b1;
    bus.core_finish = 1'b1;
    bus.core_ph     = ph;
    bus.core_ac     = ac;
    @(negedge clk);
    bus.core_o_vld  = 1'b0;
    bus.core_finish = 1'b0;
    chk({tag, "_res_vld"}, 32'(bus.res_vld), 1);
    chk({tag, "_res_id"}, 32'(bus.res_id), 32'(exp_id));
    chk({tag, "_res_ph"}, bus.res_ph, ph);
    chk({tag, "_res_ac"}, bus.res_ac, ac);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, base_res, base_tmo, q0, first, r;

    bus.req_vld     = '0;
    bus.req_x1      = '0;
    bus.req_x2      = '0;
    bus.core_o_vld  = 1'b0;
    bus.core_finish = 1'b0;
    bus.core_ph     = '0;
    bus.core_ac     = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rdy", 32'(bus.req_rdy), 0);
    chk("rst_ivld", 32'(bus.core_i_vld), 0);
    chk("rst_res_vld", 32'(bus.res_vld), 0);
    chk("rst_tmo", 32'(bus.timeout_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin: requesters 0 and 2 always valid -> 0, 2, 0.
    base = n_ivld;
    q0   = gq.size();
    bus.req_x1[0*XW +: XW] = 16'd100;
    bus.req_x2[0*XW +: XW] = 16'd101;
    bus.req_x1[2*XW +: XW] = 16'd300;
    bus.req_x2[2*XW +: XW] = 16'd301;
    bus.req_vld = 4'b0101;
    respond(32'd10, 32'd500, 0, "rr0");
    respond(32'd11, 32'd501, 2, "rr1");
    respond(32'd12, 32'd502, 0, "rr2");
    bus.req_vld = '0;
    #3;
    chk("rr_ivld_cnt", 32'(n_ivld - base), 15);
    chk("rr_grants", 32'(gq.size() - q0), 3);
    chk("rr_g0", 32'(gq[q0]), 0);
    chk("rr_g1", 32'(gq[q0+1]), 2);
    chk("rr_g2", 32'(gq[q0+2]), 0);
    chk("rr_onehot", 32'(n_multi), 0);
    chk("rr_last_x1", 32'(bus.core_x1), 100);

    // Single frame from requester 1.
    @(negedge clk);
    base = n_ivld;
    for (int i = 1; i <= FL; i++) send(1, 16'(i), 16'(2*i), "sf");
    bus.req_vld[1] = 1'b0;
    #3;
    chk("sf_ivld_cnt", 32'(n_ivld - base), 5);
    chk("sf_rdy_drop", 32'(bus.req_rdy), 0);
    respond(-32'sd7, 32'd1234, 1, "sf");
    @(negedge clk);
    chk("sf_res_pulse", 32'(bus.res_vld), 0);
    chk("sf_res_hold", bus.res_ph, 32'hFFFF_FFF9);

    // Gapped stream from requester 3 with an intermediate result.
    base = n_ivld;
    for (int i = 0; i < FL; i++) begin
      send(3, 16'(40 + i), 16'(80 + i), "gap");
      bus.req_vld[3] = 1'b0;
      if (i < FL - 1) begin
        repeat (8) @(negedge clk);
        chk("gap_still_stream", 32'(bus.req_rdy), 32'h8);
      end
    end
    chk("gap_rdy_drop", 32'(bus.req_rdy), 0);
    bus.core_o_vld = 1'b1;
    bus.core_ph    = 32'd99;
    @(negedge clk);
    bus.core_o_vld = 1'b0;
    @(negedge clk);
    chk("gap_interm_res", 32'(bus.res_vld), 0);
    chk("gap_interm_busy", 32'(bus.busy), 1);
    #3;
    chk("gap_ivld_cnt", 32'(n_ivld - base), 5);
    respond(32'd77, 32'd4321, 3, "gap");

    // Timeout on requester 0 while requester 1 waits.
    @(negedge clk);
    base_res = n_res;
    base_tmo = n_tmo;
    bus.req_x1[1*XW +: XW] = 16'h11;
    bus.req_x2[1*XW +: XW] = 16'h22;
    bus.req_vld[1] = 1'b1;
    for (int i = 0; i < FL; i++) send(0, 16'(200 + i), 16'(300 + i), "tmo");
    bus.req_vld[0] = 1'b0;
    first = 0;
    r     = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (bus.timeout_err && first == 0) first = k;
      if (bus.res_vld) r++;
    end
    #3;
    chk("tmo_when", 32'(first), 16);
    chk("tmo_no_res", 32'(r), 0);
    chk("tmo_pulse_cnt", 32'(n_tmo - base_tmo), 1);
    chk("tmo_res_cnt", 32'(n_res - base_res), 0);
    chk("tmo_next_grant", 32'(gq[gq.size()-1]), 1);
    for (int i = 0; i < FL; i++) send(1, 16'(500 + i), 16'(600 + i), "tmo_next");
    bus.req_vld[1] = 1'b0;
    respond(32'd5, 32'd6, 1, "tmo_next");

    // Spurious final results in IDLE and mid-STREAM.
    bus.core_o_vld  = 1'b1;
    bus.core_finish = 1'b1;
    bus.core_ph     = 32'hDEAD;
    @(negedge clk);
    bus.core_o_vld  = 1'b0;
    bus.core_finish = 1'b0;
    @(negedge clk);
    chk("sp_idle_res", 32'(bus.res_vld), 0);
    chk("sp_idle_hold", bus.res_ph, 5);
    send(2, 16'd1, 16'd2, "sp");
    send(2, 16'd3, 16'd4, "sp");
    bus.req_vld[2]  = 1'b0;
    bus.core_o_vld  = 1'b1;
    bus.core_finish = 1'b1;
    @(negedge clk);
    bus.core_o_vld  = 1'b0;
    bus.core_finish = 1'b0;
    chk("sp_stream_res", 32'(bus.res_vld), 0);
    chk("sp_stream_rdy", 32'(bus.req_rdy), 32'h4);
    for (int i = 0; i < 3; i++) send(2, 16'(5 + i), 16'(9 + i), "sp");
    bus.req_vld[2] = 1'b0;
    #3;
    base_res = n_res;
    respond(-32'sd100, 32'd9, 2, "sp");
    @(negedge clk);
    #3;
    chk("sp_res_once", 32'(n_res - base_res), 1);

    // Reset in the middle of a frame from requester 3.
    @(negedge clk);
    for (int i = 0; i < 3; i++) send(3, 16'(11 + i), 16'(21 + i), "mid");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_rdy", 32'(bus.req_rdy), 0);
    chk("arst_ivld", 32'(bus.core_i_vld), 0);
    chk("arst_x1", 32'(bus.core_x1), 0);
    chk("arst_res_id", 32'(bus.res_id), 0);
    chk("arst_res_ph", bus.res_ph, 0);
    chk("arst_res_ac", bus.res_ac, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_vld = 4'b1001;
    for (int i = 1; i <= FL; i++) send(0, 16'(70 + i), 16'(90 + i), "post");
    bus.req_vld = '0;
    #3;
    chk("post_first_grant", 32'(gq[gq.size()-1]), 0);
    respond(32'd1, 32'd2, 0, "post");
    @(negedge clk);
    chk("post_onehot", 32'(n_multi), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ac_ph_frame_arbiter.md
Name: ac_ph_frame_arbiter

Overview:
Shares one AC_PH amplitude/phase core between NREQ sample-pair sources. Grants the core to one requester for a whole frame of FRAME_LENGTH (x1,x2) samples, using round-robin. Forwards the samples to the core, waits for the core's final result (o_vld with finish), then returns ph/ac tagged with the requester id. Sits between the ADC/channel front-ends and the AC_PH instance.

Parameters:
NREQ, 4, number of requesters (2..16)
X_WIDTH, 16, signed sample width, matches the core
FRAME_LENGTH, 5, samples per frame forwarded per grant
TIMEOUT, 1024, max cycles in WAIT_RES before abort
ID_W, $clog2(NREQ), requester id width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_vld  in  NREQ  per-requester sample valid
req_x1  in  NREQ*X_WIDTH  packed channel-1 samples, requester i at [i*X_WIDTH +: X_WIDTH]
req_x2  in  NREQ*X_WIDTH  packed channel-2 samples, same packing
req_rdy  out  NREQ  per-requester ready, one-hot or zero
core_i_vld  out  1  sample strobe to the core
core_x1  out  X_WIDTH  signed sample to the core
core_x2  out  X_WIDTH  signed sample to the core
core_o_vld  in  1  core result valid
core_finish  in  1  core final-result flag
core_ph  in  32  core phase difference, signed
core_ac  in  32  core magnitude, unsigned
res_vld  out  1  one-cycle result pulse
res_id  out  ID_W  requester owning the result
res_ph  out  32  captured phase
res_ac  out  32  captured magnitude
busy  out  1  high in STREAM or WAIT_RES
timeout_err  out  1  one-cycle pulse on WAIT_RES timeout

Behaviour:
- Reset: all outputs 0; state IDLE; sample_cnt=0; last_grant=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, STREAM, WAIT_RES.
- IDLE:
  - If any req_vld is high, pick the first set bit scanning from last_grant+1 with wrap.
  - Register the winner in grant; go to STREAM.
  - No req_rdy is asserted in IDLE.
- STREAM:
  - req_rdy[grant] = 1 (combinational from state/grant); all other req_rdy bits are 0.
  - A sample is accepted when req_vld[grant] && req_rdy[grant].
  - Next cycle: core_i_vld=1 and core_x1/x2 = the registered accepted sample (1-cycle latency). Otherwise core_i_vld=0; core_x1/x2 hold their last value.
  - Gaps (req_vld low) are allowed and do not advance sample_cnt.
  - Valid bits of non-granted requesters are ignored; they wait.
  - When the sample with sample_cnt==FRAME_LENGTH-1 is accepted: sample_cnt<=0; state<=WAIT_RES. req_rdy drops the cycle after that acceptance.
- WAIT_RES:
  - Timeout counter starts at 0 and increments every cycle.
  - On core_o_vld && core_finish: capture res_ph/res_ac, res_id=grant; res_vld=1 for exactly one cycle (next cycle); last_grant<=grant; go to IDLE.
  - core_o_vld without core_finish (intermediate results) is ignored.
  - If the counter reaches TIMEOUT-1 with no final result: timeout_err pulse 1 cycle; res_vld stays 0; last_grant<=grant; go to IDLE.
  - If a final result and the timeout occur in the same cycle, the result wins and there is no error.
- core_o_vld in IDLE or STREAM is ignored (stale/spurious).
- Back-to-back frames: IDLE costs one cycle between frames, so minimum frame period is FRAME_LENGTH+2 cycles plus core latency.
- res_ph/res_ac/res_id hold their value until the next capture.
- Reset mid-operation: everything returns to reset values immediately. A partial frame already in the core is not flushed; the integration issues core reset together with rst.
- busy = (state != IDLE).

Decomposition:
- Package ac_ph_arb_pkg:
  - state enum (IDLE, STREAM, WAIT_RES).
  - Core result width constant RES_W=32.
  - Function rr_pick(vec, last) returning the next index.
- Sub-module rr_arbiter (NREQ, combinational pick + registered last_grant update input) is natural. The FSM, counters and datapath mux stay in the top.

Test Plan:
- Single frame: NREQ=4, FRAME_LENGTH=5, requester 1 sends x1=1..5, x2=2,4..10 continuously -> core_i_vld pulses 5 consecutive cycles, 1 cycle after acceptance, with matching data; a model returns ph=-7, ac=1234 with finish -> res_vld one cycle, res_id=1, res_ph=-7, res_ac=1234.
- Round-robin: requesters 0 and 2 hold req_vld high for 3 frames -> grant order 0,2,0; req_rdy never has two bits high; req_rdy[2]=0 during frame of 0.
- Gapped stream: requester 3 sends 5 samples each separated by 8 idle cycles -> exactly 5 core_i_vld pulses, state leaves STREAM only after the 5th; intermediate core_o_vld (finish=0) ignored.
- Timeout: TIMEOUT=16, core never asserts finish -> timeout_err pulse 16 cycles after WAIT_RES entry, res_vld stays 0, next requester served.
- Spurious result: core_o_vld&&core_finish pulsed in IDLE and mid-STREAM -> no res_vld; the real result later is reported once.
- Reset mid-frame: assert rst after 3 of 5 samples -> all outputs 0 asynchronously; after release requester 0 wins first and a full 5-sample frame follows.
